// File: rtl/lsq_part_pkg.sv
// Shared types for the partitioned LSQ reconfiguration controller.
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif

package lsq_part_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      GATE  = 3'd2,
      WAKE  = 3'd3,
      DONE  = 3'd4
   } lsqPartState_t;

   localparam int unsigned LSQ_PARTS = `STRUCT_PARTS_LSQ;

   typedef logic [LSQ_PARTS-1:0] lsqPartMask_t;

endpackage

// File: rtl/lsq_wake_timer.sv
// Down-counter that times the wake-up latency of newly enabled RAM partitions.
module lsq_wake_timer #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] loadVal,
   input  logic             decrement,
   output logic             isZero_c
);

   logic [CNT_W-1:0] count;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadVal;
      end else if (decrement && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign isZero_c = (count == '0);

endmodule

// File: rtl/lsq_partition_ctrl.sv
// Sequences LSQ RAM partition reconfiguration: stall, drain, gate, wake, done.
module lsq_partition_ctrl
   import lsq_part_pkg::*;
#(
   parameter int unsigned NUM_PARTS   = LSQ_PARTS,
   parameter int unsigned WAKE_CYCLES = 4,
   parameter int unsigned CNT_W       = $clog2(WAKE_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reconfigReq_i,
   input  logic [NUM_PARTS-1:0] newPartActive_i,
   input  logic                 lsqEmpty_i,
   output logic [NUM_PARTS-1:0] lsqPartitionActive_o,
   output logic                 stqRamReady_o,
   output logic                 stallDispatch_o,
   output logic                 busy_o,
   output logic                 reconfigDone_o,
   output logic                 reconfigErr_o
);

   lsqPartState_t        state;
   lsqPartState_t        stateNext;
   logic [NUM_PARTS-1:0] pending;
   logic [NUM_PARTS-1:0] pendingNext;
   logic [NUM_PARTS-1:0] maskNext;
   logic                 readyNext;
   logic                 busyNext;
   logic                 doneNext;
   logic                 errNext;
   logic                 timerLoad_c;
   logic                 timerDec_c;
   logic                 timerZero_c;

   lsq_wake_timer #(
      .CNT_W(CNT_W)
   ) u_wakeTimer (
      .clk       (clk),
      .reset     (reset),
      .load      (timerLoad_c),
      .loadVal   (CNT_W'(WAKE_CYCLES - 1)),
      .decrement (timerDec_c),
      .isZero_c  (timerZero_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and next-output decode; outputs act on the edge that leaves a state.
   always_comb begin
      stateNext   = state;
      pendingNext = pending;
      maskNext    = lsqPartitionActive_o;
      readyNext   = stqRamReady_o;
      doneNext    = 1'b0;
      errNext     = 1'b0;
      timerLoad_c = 1'b0;
      timerDec_c  = 1'b0;

      case (state)
         IDLE: begin
            if (reconfigReq_i) begin
               if (newPartActive_i == '0) begin
                  errNext = 1'b1;
               end else if (newPartActive_i == lsqPartitionActive_o) begin
                  doneNext = 1'b1;
               end else begin
                  pendingNext = newPartActive_i;
                  stateNext   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (lsqEmpty_i) begin
               stateNext = GATE;
            end
         end
         GATE: begin
            maskNext  = pending;
            readyNext = 1'b0;
            // Only newly enabled partitions need the wake-up delay.
            if ((pending & ~lsqPartitionActive_o) != '0) begin
               timerLoad_c = 1'b1;
               stateNext   = WAKE;
            end else begin
               stateNext = DONE;
            end
         end
         WAKE: begin
            if (timerZero_c) begin
               stateNext = DONE;
            end else begin
               timerDec_c = 1'b1;
            end
         end
         DONE: begin
            readyNext = 1'b1;
            doneNext  = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      busyNext = (stateNext != IDLE);
   end

   // Registered outputs and pending mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending              <= '0;
         lsqPartitionActive_o <= '1;
         stqRamReady_o        <= 1'b1;
         stallDispatch_o      <= 1'b0;
         busy_o               <= 1'b0;
         reconfigDone_o       <= 1'b0;
         reconfigErr_o        <= 1'b0;
      end else begin
         pending              <= pendingNext;
         lsqPartitionActive_o <= maskNext;
         stqRamReady_o        <= readyNext;
         stallDispatch_o      <= busyNext;
         busy_o               <= busyNext;
         reconfigDone_o       <= doneNext;
         reconfigErr_o        <= errNext;
      end
   end

endmodule

// File: tb/tb_lsq_partition_ctrl.sv
// Bench for lsq_partition_ctrl: directed vector table, latency checks, randomized run vs. model.
module tb_lsq_partition_ctrl;

   localparam int unsigned WAKE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       reconfigReq;
   logic [3:0] newPartActive;
   logic       lsqEmpty;
   logic [3:0] partActive;
   logic       ramReady;
   logic       stall;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: transaction timestamps rather than a state machine.
   logic [3:0] mMask;
   logic [3:0] mPend;
   logic       mReady;
   logic       mBusy;
   logic       mDone;
   logic       mErr;
   int         gateEdge;
   int         doneEdge;

   typedef struct {
      logic       rst;
      logic       req;
      logic [3:0] nm;
      logic       emp;
      logic [3:0] eMask;
      logic       eReady;
      logic       eStall;
      logic       eBusy;
      logic       eDone;
      logic       eErr;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   lsq_partition_ctrl #(
      .NUM_PARTS   (4),
      .WAKE_CYCLES (WAKE)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .reconfigReq_i        (reconfigReq),
      .newPartActive_i      (newPartActive),
      .lsqEmpty_i           (lsqEmpty),
      .lsqPartitionActive_o (partActive),
      .stqRamReady_o        (ramReady),
      .stallDispatch_o      (stall),
      .busy_o               (busy),
      .reconfigDone_o       (done),
      .reconfigErr_o        (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelEdge();
      cyc++;
      mDone = 1'b0;
      mErr  = 1'b0;
      if (reset) begin
         mMask    = 4'hF;
         mPend    = 4'h0;
         mReady   = 1'b1;
         mBusy    = 1'b0;
         gateEdge = -1;
         doneEdge = -1;
      end else if (!mBusy) begin
         if (reconfigReq) begin
            if (newPartActive == 4'h0) mErr = 1'b1;
            else if (newPartActive == mMask) mDone = 1'b1;
            else begin
               mBusy    = 1'b1;
               mPend    = newPartActive;
               gateEdge = -1;
               doneEdge = -1;
            end
         end
      end else if (gateEdge < 0) begin
         if (lsqEmpty) gateEdge = cyc + 1;
      end else if (cyc == gateEdge) begin
         doneEdge = cyc + 1 + (((mPend & ~mMask) != 4'h0) ? int'(WAKE) : 0);
         mMask    = mPend;
         mReady   = 1'b0;
      end else if (cyc == doneEdge) begin
         mReady = 1'b1;
         mBusy  = 1'b0;
         mDone  = 1'b1;
      end
   endtask

   task automatic applyCycle(input logic r, input logic q, input logic [3:0] m, input logic e);
      reset         = r;
      reconfigReq   = q;
      newPartActive = m;
      lsqEmpty      = e;
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic checkModel();
      chk("mask", 32'(partActive), 32'(mMask));
      chk("ready", 32'(ramReady), 32'(mReady));
      chk("stall", 32'(stall), 32'(mBusy));
      chk("busy", 32'(busy), 32'(mBusy));
      chk("done", 32'(done), 32'(mDone));
      chk("err", 32'(err), 32'(mErr));
      chk("maskNonZero", 32'(partActive != 4'h0), 32'd1);
      chk("readyLowStall", 32'(ramReady | stall), 32'd1);
   endtask

   task automatic addVec(input logic r, input logic q, input logic [3:0] m, input logic e,
                         input logic [3:0] xm, input logic xr, input logic xs, input logic xb,
                         input logic xd, input logic xe);
      vec_t v;
      v.rst = r; v.req = q; v.nm = m; v.emp = e;
      v.eMask = xm; v.eReady = xr; v.eStall = xs; v.eBusy = xb; v.eDone = xd; v.eErr = xe;
      vq.push_back(v);
   endtask

   // Request a new mask with the LSQ empty and count edges until the done pulse.
   task automatic measure(input string name, input logic [3:0] m, input int expLat);
      int n;
      applyCycle(1'b0, 1'b1, m, 1'b1);
      checkModel();
      n = 0;
      while (!done && n < 40) begin
         applyCycle(1'b0, 1'b0, 4'h0, 1'b1);
         checkModel();
         n++;
      end
      chk(name, 32'(n), 32'(expLat));
      chk({name, "Mask"}, 32'(partActive), 32'(m));
   endtask

   initial begin
      //     rst  req  nm     emp   mask  rdy  stl  bsy  dne  err
      addVec(1'b1,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 0 reset
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 1 idle
      addVec(1'b0,1'b1,4'h3,1'b1, 4'hF,1'b1,1'b1,1'b1,1'b0,1'b0); // 2 shrink req -> DRAIN
      addVec(1'b0,1'b0,4'h0,1'b1, 4'hF,1'b1,1'b1,1'b1,1'b0,1'b0); // 3 -> GATE
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h3,1'b0,1'b1,1'b1,1'b0,1'b0); // 4 gated -> DONE
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h3,1'b1,1'b0,1'b0,1'b1,1'b0); // 5 done pulse
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h3,1'b1,1'b0,1'b0,1'b0,1'b0); // 6 idle
      addVec(1'b0,1'b1,4'hF,1'b0, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 7 grow req -> DRAIN
      addVec(1'b0,1'b0,4'h0,1'b0, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 8 draining
      addVec(1'b0,1'b1,4'h1,1'b0, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 9 req ignored
      addVec(1'b0,1'b0,4'h0,1'b0, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 10
      addVec(1'b0,1'b0,4'h0,1'b0, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 11
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h3,1'b1,1'b1,1'b1,1'b0,1'b0); // 12 -> GATE
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b0,1'b1,1'b1,1'b0,1'b0); // 13 -> WAKE
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b0,1'b1,1'b1,1'b0,1'b0); // 14
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b0,1'b1,1'b1,1'b0,1'b0); // 15
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b0,1'b1,1'b1,1'b0,1'b0); // 16
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b0,1'b1,1'b1,1'b0,1'b0); // 17 -> DONE
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b1,1'b0); // 18 done pulse
      addVec(1'b0,1'b1,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b1); // 19 zero mask -> err
      addVec(1'b0,1'b1,4'hF,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b1,1'b0); // 20 same mask -> done
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 21
      addVec(1'b0,1'b1,4'h1,1'b1, 4'hF,1'b1,1'b1,1'b1,1'b0,1'b0); // 22 shrink to 0001
      addVec(1'b0,1'b0,4'h0,1'b1, 4'hF,1'b1,1'b1,1'b1,1'b0,1'b0); // 23
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h1,1'b0,1'b1,1'b1,1'b0,1'b0); // 24
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h1,1'b1,1'b0,1'b0,1'b1,1'b0); // 25
      addVec(1'b0,1'b1,4'h6,1'b1, 4'h1,1'b1,1'b1,1'b1,1'b0,1'b0); // 26 grow to 0110
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h1,1'b1,1'b1,1'b1,1'b0,1'b0); // 27
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h6,1'b0,1'b1,1'b1,1'b0,1'b0); // 28 WAKE
      addVec(1'b0,1'b0,4'h0,1'b1, 4'h6,1'b0,1'b1,1'b1,1'b0,1'b0); // 29 WAKE
      addVec(1'b1,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 30 reset mid-WAKE
      addVec(1'b1,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 31
      addVec(1'b1,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 32
      addVec(1'b0,1'b0,4'h0,1'b0, 4'hF,1'b1,1'b0,1'b0,1'b0,1'b0); // 33 idle after reset

      foreach (vq[i]) begin
         applyCycle(vq[i].rst, vq[i].req, vq[i].nm, vq[i].emp);
         chk($sformatf("vec%0d.mask", i), 32'(partActive), 32'(vq[i].eMask));
         chk($sformatf("vec%0d.ready", i), 32'(ramReady), 32'(vq[i].eReady));
         chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vq[i].eStall));
         chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vq[i].eBusy));
         chk($sformatf("vec%0d.done", i), 32'(done), 32'(vq[i].eDone));
         chk($sformatf("vec%0d.err", i), 32'(err), 32'(vq[i].eErr));
      end

      // Latency with no drain stall: shrink 3 edges, grow 3+WAKE edges.
      measure("latShrink", 4'h1, 3);
      applyCycle(1'b0, 1'b0, 4'h0, 1'b1);
      checkModel();
      measure("latGrow", 4'h7, 3 + int'(WAKE));
      applyCycle(1'b0, 1'b0, 4'h0, 1'b1);
      checkModel();

      // Randomized traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         logic       r;
         logic       q;
         logic [3:0] m;
         logic       e;
         r = ($urandom_range(0, 499) == 0);
         q = ($urandom_range(0, 3) == 0);
         m = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) m = mMask;
         e = ($urandom_range(0, 1) == 1);
         applyCycle(r, q, m, e);
         checkModel();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
